keypad_debouncer: RTL

- Front-end stage directly upstream of the door-lock top.
- Takes raw, bouncy, asynchronous key contacts (10 digit keys, confirm key, shuffle key) and delivers clean single-cycle press pulses on `digit_buttons`, `confirm_button` and `shuffle_button`.
- Rejects chords: when two or more keys are pressed together, no further pulses are issued until every key has been released.

---
 rtl/keypad_debouncer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/keypad_debouncer.sv
// Keypad front end: synchronizes and debounces 12 raw key contacts, then issues
// single-cycle press pulses with chord rejection until every key is released.
module keypad_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_digit,
  input  logic       raw_confirm,
  input  logic       raw_shuffle,
  output logic [9:0] digit_buttons,
  output logic       confirm_button,
  output logic       shuffle_button,
  output logic       key_held,
  output logic       chord_error
);

  localparam int unsigned NKEYS  = 12;
  localparam int unsigned NDIG   = 10;
  localparam int unsigned CONF_B = 10;
  localparam int unsigned SHUF_B = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  logic [NKEYS-1:0] key_c;
  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] stable_d;
  logic [NKEYS-1:0] rise_q;
  logic [NKEYS-1:0] pulse_c;
  logic [NKEYS-1:0] pulse_q;
  logic [3:0]       rise_cnt_c;
  logic             other_held_c;
  state_t           state_q;
  state_t           state_c;

  assign key_c = {raw_shuffle, raw_confirm, raw_digit};

  // Two-flop synchronizer for the asynchronous contacts.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_c;
      s2 <= s1;
    end
  end

  // Per-key debounce: the level must hold against the stable state for a full count.
  for (genvar i = 0; i < NKEYS; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             stable_bit;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt        <= '0;
        stable_bit <= 1'b0;
      end else if (s2[i] == stable_bit) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable_bit <= s2[i];
        cnt        <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign stable[i] = stable_bit;
  end

  // Rise detection is registered together with an aligned copy of the stable vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= '0;
      rise_q   <= '0;
      key_held <= 1'b0;
    end else begin
      stable_d <= stable;
      rise_q   <= stable & ~stable_d;
      key_held <= |stable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_c;
    end
  end

  // Chord arbitration on the registered rise vector.
  always_comb begin
    state_c      = state_q;
    pulse_c      = '0;
    rise_cnt_c   = 4'($countones(rise_q));
    other_held_c = |(stable_d & ~rise_q);
    case (state_q)
      IDLE: begin
        if (rise_q != '0) begin
          if ((rise_cnt_c == 4'd1) && !other_held_c) begin
            pulse_c = rise_q;
            state_c = HELD;
          end else begin
            state_c = BLOCKED;
          end
        end
      end
      HELD: begin
        if (rise_q != '0) begin
          state_c = BLOCKED;
        end else if (stable_d == '0) begin
          state_c = IDLE;
        end
      end
      BLOCKED: begin
        if (stable_d == '0) begin
          state_c = IDLE;
        end
      end
      default: begin
        state_c = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q     <= '0;
      chord_error <= 1'b0;
    end else begin
      pulse_q     <= pulse_c;
      chord_error <= (state_c == BLOCKED);
    end
  end

  assign digit_buttons  = pulse_q[NDIG-1:0];
  assign confirm_button = pulse_q[CONF_B];
  assign shuffle_button = pulse_q[SHUF_B];

endmodule
